// File: rtl/framed_program_loader_if.sv
`default_nettype none
//==============================================================================
// Module      : framed_program_loader_if
// Description : Byte-stream input and instruction-memory write port bundle
//               for the framed program loader.
// Revision    : 1.0 - initial release
//==============================================================================
interface framed_program_loader_if;
    logic        uart_out_valid;
    logic [7:0]  uart_out_data;
    logic        uart_out_ready;
    logic [31:0] inst_mem_in_addr;
    logic [31:0] inst_mem_in_data;
    logic        inst_mem_in_valid;
    logic        inst_mem_in_ready;

    // Environment side: UART byte source and instruction memory.
    modport master (
        output uart_out_valid,
        output uart_out_data,
        input  uart_out_ready,
        input  inst_mem_in_addr,
        input  inst_mem_in_data,
        input  inst_mem_in_valid,
        output inst_mem_in_ready
    );

    // Loader side.
    modport slave (
        input  uart_out_valid,
        input  uart_out_data,
        output uart_out_ready,
        output inst_mem_in_addr,
        output inst_mem_in_data,
        output inst_mem_in_valid,
        input  inst_mem_in_ready
    );
endinterface
`default_nettype wire

// File: rtl/framed_program_loader.sv
`default_nettype none
//==============================================================================
// Module      : framed_program_loader
// Description : Consumes a framed program image (32-bit LE word count, payload
//               words, 8-bit payload checksum) from a byte stream and writes
//               the words to consecutive instruction-memory addresses.
//               Reports a sticky completed or error status.
// Revision    : 1.0 - initial release
//==============================================================================
module framed_program_loader #(
    parameter int ADDR_WIDTH = 10
) (
    input  logic                    clk,
    input  logic                    reset,
    framed_program_loader_if.slave  bus,
    output logic                    completed,
    output logic                    error
);

    localparam logic [2:0] S_HDR     = 3'd0;
    localparam logic [2:0] S_PAYLOAD = 3'd1;
    localparam logic [2:0] S_WRITE   = 3'd2;
    localparam logic [2:0] S_CSUM    = 3'd3;
    localparam logic [2:0] S_DONE    = 3'd4;
    localparam logic [2:0] S_ERROR   = 3'd5;

    // Largest legal word count, kept 33 bits wide so 2^32 is representable.
    localparam logic [32:0] c_max_words = 33'd1 << ADDR_WIDTH;
    // Keeps only the low ADDR_WIDTH bits of the word counter (all ones at 32).
    localparam logic [31:0] c_addr_mask = c_max_words[31:0] - 32'd1;

    logic [2:0]  r_state;
    logic [1:0]  r_byte_pos;
    logic [23:0] r_shift;      // first three bytes of the current word
    logic [31:0] r_count;
    logic [31:0] r_word_cnt;
    logic [7:0]  r_csum;
    logic        r_ready;
    logic        r_mem_valid;
    logic [31:0] r_mem_addr;
    logic [31:0] r_mem_data;
    logic        r_completed;
    logic        r_error;

    logic        w_accept;
    logic [31:0] w_word;
    logic [31:0] w_words_next;

    // Ready is registered, so acceptance depends only on state and the source.
    assign w_accept     = bus.uart_out_valid && r_ready;
    assign w_word       = {bus.uart_out_data, r_shift};
    assign w_words_next = r_word_cnt + 32'd1;

    // Frame parser, word assembler and write-port sequencer.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= S_HDR;
            r_byte_pos  <= 2'd0;
            r_shift     <= 24'd0;
            r_count     <= 32'd0;
            r_word_cnt  <= 32'd0;
            r_csum      <= 8'd0;
            r_ready     <= 1'b0;
            r_mem_valid <= 1'b0;
            r_mem_addr  <= 32'd0;
            r_mem_data  <= 32'd0;
            r_completed <= 1'b0;
            r_error     <= 1'b0;
        end else begin
            case (r_state)
                S_HDR: begin
                    r_ready <= 1'b1;
                    if (w_accept) begin
                        r_byte_pos <= r_byte_pos + 2'd1;
                        r_shift    <= {bus.uart_out_data, r_shift[23:8]};
                        if (r_byte_pos == 2'd3) begin
                            r_count <= w_word;
                            if (w_word == 32'd0) begin
                                r_state <= S_CSUM;
                            end else if ({1'b0, w_word} > c_max_words) begin
                                r_state <= S_ERROR;
                                r_error <= 1'b1;
                            end else begin
                                r_state <= S_PAYLOAD;
                            end
                        end
                    end
                end
                S_PAYLOAD: begin
                    if (w_accept) begin
                        r_byte_pos <= r_byte_pos + 2'd1;
                        r_shift    <= {bus.uart_out_data, r_shift[23:8]};
                        r_csum     <= r_csum + bus.uart_out_data;
                        if (r_byte_pos == 2'd3) begin
                            r_mem_data  <= w_word;
                            r_mem_valid <= 1'b1;
                            r_ready     <= 1'b0;
                            r_state     <= S_WRITE;
                        end
                    end
                end
                S_WRITE: begin
                    if (bus.inst_mem_in_ready) begin
                        r_mem_valid <= 1'b0;
                        r_ready     <= 1'b1;
                        r_word_cnt  <= w_words_next;
                        r_mem_addr  <= w_words_next & c_addr_mask;
                        r_state     <= (w_words_next == r_count) ? S_CSUM : S_PAYLOAD;
                    end
                end
                S_CSUM: begin
                    if (w_accept) begin
                        if (bus.uart_out_data == r_csum) begin
                            r_state     <= S_DONE;
                            r_completed <= 1'b1;
                            r_ready     <= 1'b0;
                        end else begin
                            r_state <= S_ERROR;
                            r_error <= 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    r_ready <= 1'b0;
                end
                S_ERROR: begin
                    // Keep draining the stream so the sender never stalls.
                    r_ready <= 1'b1;
                end
                default: begin
                    r_state <= S_ERROR;
                    r_error <= 1'b1;
                    r_ready <= 1'b1;
                end
            endcase
        end
    end

    assign bus.uart_out_ready    = r_ready;
    assign bus.inst_mem_in_valid = r_mem_valid;
    assign bus.inst_mem_in_addr  = r_mem_addr;
    assign bus.inst_mem_in_data  = r_mem_data;
    assign completed             = r_completed;
    assign error                 = r_error;

endmodule
`default_nettype wire

// File: tb/tb_framed_program_loader.sv
`default_nettype none
//==============================================================================
// Module      : tb_framed_program_loader
// Description : Self-checking bench for framed_program_loader: table of
//               frames plus hand-written backpressure, full-size and
//               mid-payload reset sequences; writes checked via a queue.
// Revision    : 1.0 - initial release
//==============================================================================
module tb_framed_program_loader;

    localparam int ADDR_WIDTH = 10;
    localparam int MAX_WORDS  = 1 << ADDR_WIDTH;

    typedef struct {
        logic [31:0]       count;
        int                nw;
        logic [2:0][31:0]  w;
        logic [7:0]        trailer;
        bit                exp_done;
        bit                exp_err;
    } vec_t;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    logic clk;
    logic reset;
    logic completed;
    logic error;

    framed_program_loader_if bus ();

    framed_program_loader #(.ADDR_WIDTH(ADDR_WIDTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
        .completed (completed),
        .error     (error)
    );

    int     checks = 0;
    int     errors = 0;
    wr_t    exp_q[$];
    wr_t    mon_e;
    logic [31:0] last_addr = 32'hFFFF_FFFF;
    vec_t   vecs[7];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Write monitor: inputs change just after posedge, so negedge values are
    // exactly what the next rising edge will see.
    always @(negedge clk) begin
        if (reset && bus.inst_mem_in_valid && bus.inst_mem_in_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: got addr %h data %h expected none",
                         bus.inst_mem_in_addr, bus.inst_mem_in_data);
            end else begin
                mon_e = exp_q.pop_front();
                check("write_addr", bus.inst_mem_in_addr, mon_e.addr);
                check("write_data", bus.inst_mem_in_data, mon_e.data);
            end
            check("uart_ready_during_write", {31'd0, bus.uart_out_ready}, 32'd0);
            last_addr = bus.inst_mem_in_addr;
        end
    end

    task automatic send_byte(input logic [7:0] b);
        int t;
        t = 0;
        bus.uart_out_valid = 1'b1;
        bus.uart_out_data  = b;
        @(negedge clk);
        while (!bus.uart_out_ready && t < 2000) begin
            @(negedge clk);
            t++;
        end
        if (t >= 2000) begin
            checks++;
            errors++;
            $display("FAIL byte_timeout: got ready 0 for 2000 cycles expected 1");
            bus.uart_out_valid = 1'b0;
        end else begin
            @(posedge clk);
            #1;
            bus.uart_out_valid = 1'b0;
        end
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8]);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        reset = 1'b0;
        bus.uart_out_valid    = 1'b0;
        bus.inst_mem_in_ready = 1'b1;
        #1;
        check("rst_uart_ready", {31'd0, bus.uart_out_ready}, 32'd0);
        check("rst_mem_valid",  {31'd0, bus.inst_mem_in_valid}, 32'd0);
        check("rst_mem_addr",   bus.inst_mem_in_addr, 32'd0);
        check("rst_mem_data",   bus.inst_mem_in_data, 32'd0);
        check("rst_completed",  {31'd0, completed}, 32'd0);
        check("rst_error",      {31'd0, error}, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("ready_after_reset", {31'd0, bus.uart_out_ready}, 32'd1);
    endtask

    task automatic run_frame(input vec_t v);
        bit oversize;
        oversize = (v.count > MAX_WORDS);
        if (!oversize)
            for (int j = 0; j < v.nw; j++) exp_q.push_back('{addr: j, data: v.w[j]});
        send_word(v.count);
        check("hdr_error", {31'd0, error}, {31'd0, oversize});
        if (!oversize)
            for (int j = 0; j < v.nw; j++) send_word(v.w[j]);
        send_byte(v.trailer);
        check("completed", {31'd0, completed}, {31'd0, v.exp_done});
        check("error",     {31'd0, error},     {31'd0, v.exp_err});
        check("pending_writes", exp_q.size(), 32'd0);
        if (v.exp_err) begin
            for (int j = 0; j < 3; j++) send_byte(8'h5A + 8'(j));
            check("drain_ready",     {31'd0, bus.uart_out_ready}, 32'd1);
            check("error_sticky",    {31'd0, error}, 32'd1);
            check("completed_stays", {31'd0, completed}, 32'd0);
        end else begin
            check("done_ready_low", {31'd0, bus.uart_out_ready}, 32'd0);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish by %0t expected finish", $time);
        $fatal(1);
    end

    initial begin
        logic [7:0]  sum;
        logic [31:0] w;

        reset                 = 1'b0;
        bus.uart_out_valid    = 1'b0;
        bus.uart_out_data     = 8'd0;
        bus.inst_mem_in_ready = 1'b1;

        vecs[0] = '{count: 32'd2, nw: 2, w: {32'd0, 32'hAABBCCDD, 32'h11223344},
                    trailer: 8'hB8, exp_done: 1'b1, exp_err: 1'b0};
        vecs[1] = '{count: 32'd0, nw: 0, w: '0,
                    trailer: 8'h00, exp_done: 1'b1, exp_err: 1'b0};
        vecs[2] = '{count: 32'd2, nw: 2, w: {32'd0, 32'hAABBCCDD, 32'h11223344},
                    trailer: 8'hB9, exp_done: 1'b0, exp_err: 1'b1};
        vecs[3] = '{count: 32'd1, nw: 1, w: {32'd0, 32'd0, 32'hFFFFFFFF},
                    trailer: 8'hFC, exp_done: 1'b1, exp_err: 1'b0};
        vecs[4] = '{count: 32'd3, nw: 3, w: {32'h80808081, 32'h00000000, 32'h01020304},
                    trailer: 8'h0B, exp_done: 1'b1, exp_err: 1'b0};
        vecs[5] = '{count: 32'd1025, nw: 0, w: '0,
                    trailer: 8'h00, exp_done: 1'b0, exp_err: 1'b1};
        vecs[6] = '{count: 32'hFFFFFFFF, nw: 0, w: '0,
                    trailer: 8'h00, exp_done: 1'b0, exp_err: 1'b1};

        for (int i = 0; i < 7; i++) begin
            apply_reset();
            run_frame(vecs[i]);
        end

        // Memory backpressure on the first write of the nominal image.
        apply_reset();
        exp_q.push_back('{addr: 32'd0, data: 32'h11223344});
        exp_q.push_back('{addr: 32'd1, data: 32'hAABBCCDD});
        send_word(32'd2);
        bus.inst_mem_in_ready = 1'b0;
        send_word(32'h11223344);
        check("bp_valid_rise", {31'd0, bus.inst_mem_in_valid}, 32'd1);
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            check("bp_valid_hold", {31'd0, bus.inst_mem_in_valid}, 32'd1);
            check("bp_addr_hold",  bus.inst_mem_in_addr, 32'd0);
            check("bp_data_hold",  bus.inst_mem_in_data, 32'h11223344);
            check("bp_ready_low",  {31'd0, bus.uart_out_ready}, 32'd0);
            if (k == 7) begin
                @(posedge clk);
                #1;
                bus.inst_mem_in_ready = 1'b1;
            end
        end
        @(posedge clk);
        #1;
        check("bp_valid_drop",   {31'd0, bus.inst_mem_in_valid}, 32'd0);
        check("bp_ready_return", {31'd0, bus.uart_out_ready}, 32'd1);
        send_word(32'hAABBCCDD);
        send_byte(8'hB8);
        check("bp_completed", {31'd0, completed}, 32'd1);
        check("bp_error",     {31'd0, error}, 32'd0);
        check("bp_pending",   exp_q.size(), 32'd0);

        // Largest legal image: last write lands at the top address.
        apply_reset();
        sum = 8'd0;
        for (int i = 0; i < MAX_WORDS; i++) begin
            w = i * 32'h9E3779B9 + 32'h1234;
            exp_q.push_back('{addr: i, data: w});
            sum = sum + w[7:0] + w[15:8] + w[23:16] + w[31:24];
        end
        send_word(32'd1024);
        check("max_hdr_error", {31'd0, error}, 32'd0);
        for (int i = 0; i < MAX_WORDS; i++) begin
            w = i * 32'h9E3779B9 + 32'h1234;
            send_word(w);
        end
        send_byte(sum);
        check("max_completed", {31'd0, completed}, 32'd1);
        check("max_last_addr", last_addr, 32'd1023);
        check("max_pending",   exp_q.size(), 32'd0);

        // Reset after two payload bytes, then a clean nominal load.
        apply_reset();
        send_word(32'd2);
        send_byte(8'h44);
        send_byte(8'h33);
        apply_reset();
        run_frame(vecs[0]);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/framed_program_loader.md
# framed_program_loader

Boot-time loader sitting directly downstream of the UART receive byte stream and upstream of the instruction memory write port. It consumes a framed program image: a 32-bit word count, the payload words, then a one-byte checksum. It packs bytes into little-endian words, writes them to consecutive instruction-memory word addresses, and reports `completed` or a sticky `error`. `completed` is the release condition for core and main-memory reset.

## Interface
- `ADDR_WIDTH`, default 10: instruction-memory word-address width. The maximum accepted word count is 2^ADDR_WIDTH.

- `clk`  in  1  system clock
- `reset`  in  1  asynchronous, active-low reset
- `uart_out_valid`  in  1  received byte available
- `uart_out_data`  in  8  received byte
- `uart_out_ready`  out  1  loader accepts the byte this cycle
- `inst_mem_in_addr`  out  32  word address; upper bits above ADDR_WIDTH are 0
- `inst_mem_in_data`  out  32  word to write
- `inst_mem_in_valid`  out  1  write request
- `inst_mem_in_ready`  in  1  memory accepts the write
- `completed`  out  1  image loaded and checksum matched; sticky
- `error`  out  1  oversize count or checksum mismatch; sticky

## Operation
- A byte transfer occurs on a rising edge with `uart_out_valid && uart_out_ready`. A memory write occurs on a rising edge with `inst_mem_in_valid && inst_mem_in_ready`.
- States:
  - **HDR**: collect 4 bytes into count N, little-endian (first byte is bits 7:0). After the 4th byte:
    - N == 0 → CSUM.
    - N > 2^ADDR_WIDTH → ERROR.
    - Otherwise → PAYLOAD.
  - **PAYLOAD**: collect 4 bytes into the word buffer, little-endian. After the 4th byte → WRITE.
  - **WRITE**: hold `inst_mem_in_valid` = 1 with addr and data stable until the write occurs. Then increment addr. If words written == N → CSUM, else → PAYLOAD.
  - **CSUM**: accept 1 byte and compare it with the 8-bit running sum (mod 256) of all payload bytes. Header bytes are excluded. Match → DONE, else → ERROR.
  - **DONE**: `completed` = 1. Terminal until reset.
  - **ERROR**: `error` = 1. Terminal until reset. Any further bytes are drained and discarded.
- `uart_out_ready` = 1 in HDR, PAYLOAD, CSUM and ERROR. It is 0 in WRITE and DONE, and 0 while reset is asserted.
- The byte-position counter is 2 bits and wraps 3→0 at each word boundary. The word counter is 32 bits; the address is the low ADDR_WIDTH bits of the word counter, zero-extended.
- N == 2^ADDR_WIDTH is legal. The last write goes to address 2^ADDR_WIDTH−1.
- Bytes are never accepted in the same cycle as a pending write, because ready is 0 in WRITE.

## Timing
- Reset assertion (async) forces:
  - state = HDR, all counters and checksum = 0.
  - `inst_mem_in_valid` = 0, `inst_mem_in_addr` = 0, `inst_mem_in_data` = 0.
  - `completed` = 0, `error` = 0, `uart_out_ready` = 0.
- After reset is released, `uart_out_ready` = 1 from the first clock edge.
- Reset mid-operation discards partial words and the count. Words already written to memory are not reverted.
- `inst_mem_in_valid` rises on the cycle after the 4th payload byte is accepted. If `inst_mem_in_ready` = 1 then, valid lasts exactly 1 cycle, and `uart_out_ready` returns to 1 on the following cycle.
- `completed` or `error` rises on the cycle after the checksum byte is accepted. An oversize count raises `error` on the cycle after the 4th header byte is accepted.
- With continuous valid bytes and ready memory, the cost per word is 5 cycles: 4 bytes plus 1 write.
- All outputs are registered or decoded from state only. There is no combinational path from `uart_out_valid` to any output.

## Test plan
- **Nominal load**:
  - Stimulus: bytes 02 00 00 00, 44 33 22 11, DD CC BB AA, B8.
  - Required: writes addr 0 = 0x11223344 and addr 1 = 0xAABBCCDD; `completed` = 1; `error` = 0.
- **Empty image**:
  - Stimulus: 00 00 00 00, 00.
  - Required: no memory writes; `completed` = 1 one cycle after the last byte.
- **Bad checksum**:
  - Stimulus: the nominal image with trailer B9.
  - Required: both writes still occur; `error` = 1; `completed` stays 0; 3 further bytes are accepted and discarded.
- **Memory backpressure**:
  - Stimulus: the nominal image with `inst_mem_in_ready` held 0 for 7 cycles on the first write.
  - Required: valid held 8 cycles with addr/data stable; `uart_out_ready` = 0 throughout; the result is identical to the nominal load.
- **Oversize count**:
  - Stimulus: ADDR_WIDTH = 10, header 01 04 00 00 (N = 1025).
  - Required: `error` = 1 immediately after the header; no writes.
  - Also: header 00 04 00 00 (N = 1024) is accepted, and its last write is at addr 1023.
- **Reset mid-payload**:
  - Stimulus: assert reset after 2 payload bytes, then send the nominal image.
  - Required: all outputs 0 during reset; the subsequent load completes correctly starting at addr 0.
